// File: rtl/jedro_1_regfile_2r1w_if.sv
// jedro_1_regfile_2r1w_if: access bundle for the 2-read/1-write register file.
// Signals (named from the register file's point of view):
//   ready_o              clear sequence finished, file accepts accesses
//   rs1_re_i/addr/data_o read port 1: enable, address, registered data
//   rs2_re_i/addr/data_o read port 2: enable, address, registered data
//   rd_we_i/addr/data_i  write port: enable, address, data
// Modports: master = the core side, slave = the register file.
interface jedro_1_regfile_2r1w_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  ready_o;
    logic                  rs1_re_i;
    logic [ADDR_WIDTH-1:0] rs1_addr_i;
    logic [DATA_WIDTH-1:0] rs1_data_o;
    logic                  rs2_re_i;
    logic [ADDR_WIDTH-1:0] rs2_addr_i;
    logic [DATA_WIDTH-1:0] rs2_data_o;
    logic                  rd_we_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic [DATA_WIDTH-1:0] rd_data_i;

    modport master (
        input  ready_o, rs1_data_o, rs2_data_o,
        output rs1_re_i, rs1_addr_i, rs2_re_i, rs2_addr_i, rd_we_i, rd_addr_i, rd_data_i
    );

    modport slave (
        output ready_o, rs1_data_o, rs2_data_o,
        input  rs1_re_i, rs1_addr_i, rs2_re_i, rs2_addr_i, rd_we_i, rd_addr_i, rd_data_i
    );
endinterface

// File: rtl/jedro_1_regfile_2r1w.sv
// jedro_1_regfile_2r1w: integer register file with two registered read ports,
// one write port, hardwired x0, optional write-to-read bypass and a post-reset
// clear engine that zeroes x1..xN-1 before raising ready_o.
// Ports:
//   clk_i   clock, rising edge
//   rstn_i  synchronous active-low reset
//   rf      slave modport of jedro_1_regfile_2r1w_if (ready, 2 read ports, 1 write port)
module jedro_1_regfile_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    jedro_1_regfile_2r1w_if.slave  rf
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] rs1_q, rs2_q;
    logic [DATA_WIDTH-1:0] rs1_res, rs2_res;
    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic                  clr_en, wr_en;

    // Storage is left alone while reset is held; x0 is never written.
    assign clr_en = rstn_i && state_q == CLEAR;
    assign wr_en  = rstn_i && state_q == READY && rf.rd_we_i && rf.rd_addr_i != '0;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= CLEAR;
            clr_cnt_q <= ADDR_WIDTH'(1);
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= state_d == READY;
        end
    end

    // The counter stops on its maximum value so it never wraps back to x0.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            if (clr_cnt_q == '1) begin
                state_d = READY;
            end else begin
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_en) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            mem[rf.rd_addr_i] <= rf.rd_data_i;
        end
    end

    // Read result; wr_en already excludes x0 and the CLEAR state.
    function automatic logic [DATA_WIDTH-1:0] rd_val(input logic [ADDR_WIDTH-1:0] a);
        if (state_q != READY || a == '0) return '0;
        if (BYPASS && wr_en && rf.rd_addr_i == a) return rf.rd_data_i;
        return mem[a];
    endfunction

    always_comb begin
        rs1_res = rd_val(rf.rs1_addr_i);
        rs2_res = rd_val(rf.rs2_addr_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            if (rf.rs1_re_i) rs1_q <= rs1_res;
            if (rf.rs2_re_i) rs2_q <= rs2_res;
        end
    end

    assign rf.ready_o    = ready_q;
    assign rf.rs1_data_o = rs1_q;
    assign rf.rs2_data_o = rs2_q;
endmodule

// File: tb/tb_jedro_1_regfile_2r1w.sv
// tb_jedro_1_regfile_2r1w: drives a BYPASS=1 and a BYPASS=0 instance with the
// same stimulus and checks both against a behavioural model every cycle.
module tb_jedro_1_regfile_2r1w;
    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   started = 1'b0;

    always #5 clk_i = ~clk_i;

    jedro_1_regfile_2r1w_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bif ();
    jedro_1_regfile_2r1w_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) nif ();

    assign nif.rs1_re_i   = bif.rs1_re_i;
    assign nif.rs1_addr_i = bif.rs1_addr_i;
    assign nif.rs2_re_i   = bif.rs2_re_i;
    assign nif.rs2_addr_i = bif.rs2_addr_i;
    assign nif.rd_we_i    = bif.rd_we_i;
    assign nif.rd_addr_i  = bif.rd_addr_i;
    assign nif.rd_data_i  = bif.rd_data_i;

    jedro_1_regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut_b (
        .clk_i(clk_i), .rstn_i(rstn_i), .rf(bif)
    );
    jedro_1_regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut_n (
        .clk_i(clk_i), .rstn_i(rstn_i), .rf(nif)
    );

    // Model: after release the file answers 0 for 31 edges, then every
    // register is zero and normal read-before-write semantics apply.
    logic [31:0] m_mem [32];
    int          m_cnt = 0;
    bit          m_ready = 1'b0;
    logic [31:0] e1b = '0, e2b = '0, e1n = '0, e2n = '0;

    function automatic logic [31:0] mread(input logic [4:0] a, input bit byp,
                                          input logic we, input logic [4:0] wa,
                                          input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (byp && we && wa == a) return wd;
        return m_mem[a];
    endfunction

    always @(posedge clk_i) begin
        if (!rstn_i) begin
            m_ready = 1'b0;
            m_cnt = 0;
            e1b = '0; e2b = '0; e1n = '0; e2n = '0;
        end else if (!m_ready) begin
            if (bif.rs1_re_i) begin e1b = '0; e1n = '0; end
            if (bif.rs2_re_i) begin e2b = '0; e2n = '0; end
            m_cnt++;
            if (m_cnt == 31) begin
                m_ready = 1'b1;
                for (int i = 0; i < 32; i++) m_mem[i] = '0;
            end
        end else begin
            if (bif.rs1_re_i) begin
                e1b = mread(bif.rs1_addr_i, 1'b1, bif.rd_we_i, bif.rd_addr_i, bif.rd_data_i);
                e1n = mread(bif.rs1_addr_i, 1'b0, bif.rd_we_i, bif.rd_addr_i, bif.rd_data_i);
            end
            if (bif.rs2_re_i) begin
                e2b = mread(bif.rs2_addr_i, 1'b1, bif.rd_we_i, bif.rd_addr_i, bif.rd_data_i);
                e2n = mread(bif.rs2_addr_i, 1'b0, bif.rd_we_i, bif.rd_addr_i, bif.rd_data_i);
            end
            if (bif.rd_we_i && bif.rd_addr_i != 5'd0) m_mem[bif.rd_addr_i] = bif.rd_data_i;
        end
        started = 1'b1;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (started) begin
            chk("ready_b", 32'(bif.ready_o), 32'(m_ready));
            chk("ready_n", 32'(nif.ready_o), 32'(m_ready));
            chk("rs1_b", bif.rs1_data_o, e1b);
            chk("rs2_b", bif.rs2_data_o, e2b);
            chk("rs1_n", nif.rs1_data_o, e1n);
            chk("rs2_n", nif.rs2_data_o, e2n);
        end
    end

    task automatic step(input logic rn, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic r1e, input logic [4:0] r1a,
                        input logic r2e, input logic [4:0] r2a);
        rstn_i = rn;
        bif.rd_we_i = we; bif.rd_addr_i = wa; bif.rd_data_i = wd;
        bif.rs1_re_i = r1e; bif.rs1_addr_i = r1a;
        bif.rs2_re_i = r2e; bif.rs2_addr_i = r2a;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic rst(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    initial begin
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk("reset_ready", 32'(bif.ready_o), 32'd0);
        chk("reset_rs1", bif.rs1_data_o, 32'd0);
        rst(1);
        for (int e = 1; e <= 31; e++) begin
            idle();
            chk($sformatf("ready_edge%0d", e), 32'(bif.ready_o), (e >= 31) ? 32'd1 : 32'd0);
        end
        for (int a = 1; a < 32; a++) begin
            step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 1'b1, 5'(a));
            chk("cleared_rs1", bif.rs1_data_o, 32'd0);
            chk("cleared_rs2", bif.rs2_data_o, 32'd0);
        end
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd0);
        chk("x5_rs1", bif.rs1_data_o, 32'hDEADBEEF);
        chk("x0_rs2", bif.rs2_data_o, 32'd0);
        chk("model_x5", e1b, 32'hDEADBEEF);
        step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        chk("x0_write_rs1", bif.rs1_data_o, 32'd0);
        chk("x0_write_rs2", nif.rs2_data_o, 32'd0);
        step(1'b1, 1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b0, 5'd0);
        chk("bypass_on", bif.rs1_data_o, 32'h12345678);
        chk("bypass_off", nif.rs1_data_o, 32'd0);
        chk("model_bypass", e1b, 32'h12345678);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b1, 5'd7);
        chk("after_bypass_n", nif.rs1_data_o, 32'h12345678);
        chk("after_bypass_n2", nif.rs2_data_o, 32'h12345678);
        step(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
        rst(1);
        for (int i = 0; i < 9; i++) idle();
        rst(2);
        for (int e = 1; e <= 31; e++) begin
            step(1'b1, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 1'b0, 5'd0);
            if (e >= 30) chk($sformatf("restart_ready%0d", e), 32'(bif.ready_o), (e == 31) ? 32'd1 : 32'd0);
        end
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd9);
        chk("x3_cleared", bif.rs1_data_o, 32'd0);
        chk("x9_ignored", bif.rs2_data_o, 32'd0);
        step(1'b1, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd9);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 5'd9, 32'(i), 1'b0, 5'(i), 1'b0, 5'd5);
        chk("hold_rs1", bif.rs1_data_o, 32'h55);
        chk("hold_rs2", nif.rs2_data_o, 32'h55);
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            step(($urandom_range(0, 299) != 0), $urandom_range(0, 1) == 1, wa, $urandom,
                 $urandom_range(0, 3) != 0, ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                 $urandom_range(0, 3) != 0, ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jedro_1_regfile_2r1w.md
Name: jedro_1_regfile_2r1w

Overview:
- Parametrised integer register file for the jedro_1 core, successor to the single-port regfile.
- Two independent synchronous read ports (rs1, rs2) and one write port (rd), so the decode stage reads both operands in one cycle.
- x0 is hardwired to zero. Optional write-to-read bypass.
- Built-in sequential clear engine zeroes x1..xN-1 after reset and signals completion on ready_o.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH.
- BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read data; 0 = the read returns the old value.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rstn_i  in  1  reset, synchronous, active-low.
- ready_o  out  1  high when the clear sequence is finished and the file accepts accesses.
- rs1_re_i  in  1  read enable, port 1.
- rs1_addr_i  in  ADDR_WIDTH  read address, port 1.
- rs1_data_o  out  DATA_WIDTH  registered read data, port 1.
- rs2_re_i  in  1  read enable, port 2.
- rs2_addr_i  in  ADDR_WIDTH  read address, port 2.
- rs2_data_o  out  DATA_WIDTH  registered read data, port 2.
- rd_we_i  in  1  write enable.
- rd_addr_i  in  ADDR_WIDTH  write address.
- rd_data_i  in  DATA_WIDTH  write data.

Behaviour:
- Reset:
  - rstn_i is sampled low at a rising clk_i edge; it is synchronous and active-low.
  - On reset: state <= CLEAR, clr_cnt <= 1, ready_o <= 0, rs1_data_o <= 0, rs2_data_o <= 0.
  - Storage is not touched while rstn_i stays low.
- State CLEAR, each edge with rstn_i high:
  - mem[clr_cnt] <= 0 and clr_cnt <= clr_cnt + 1.
  - When clr_cnt == NUM_REGS-1, that edge also sets state <= READY and ready_o <= 1.
  - ready_o therefore rises exactly NUM_REGS-1 edges after rstn_i is first sampled high (31 for the defaults).
  - rd_we_i is ignored: no write, no effect on the sequence.
  - An enabled read loads 0 into its data register.
- State READY:
  - Stays in READY until the next reset.
  - A reset at any point, including mid-CLEAR, restarts the sequence at clr_cnt = 1.
- Write (READY only): at an edge with rd_we_i = 1 and rd_addr_i != 0, mem[rd_addr_i] <= rd_data_i. Writes to address 0 are discarded.
- Read, per port independently:
  - Latency is 1 cycle: at an edge with re = 1, data_o loads the result and holds it until the next enabled read or reset.
  - With re = 0, data_o holds its previous value.
  - Result when addr == 0: always 0.
  - Result when BYPASS = 1 and rd_we_i = 1, rd_addr_i == addr and addr != 0 at the same edge: rd_data_i.
  - Otherwise the result is mem[addr] as it was before this edge's write.
- Both ports may read the same address in the same cycle, and both get identical data.
- Reads and the write are independent; no stalls or back-pressure in READY.
- No combinational path from inputs to outputs. Storage is uninitialised apart from the clear engine.
- clr_cnt is ADDR_WIDTH bits and never wraps: the transition to READY occurs on the maximum value.

Test Plan:
- Release reset, hold all enables low, count edges → ready_o = 0 for 30 edges and 1 after the 31st. Then read x1..x31 on both ports → all return 0x00000000.
- In READY, write x5 = 0xDEADBEEF. Next cycle read rs1 = x5, rs2 = x0 → one cycle later rs1_data_o = 0xDEADBEEF, rs2_data_o = 0.
- Write x0 = 0xFFFFFFFF, then read x0 → 0.
- Same-edge write x7 = 0x12345678 with rs1 reading x7, x7 previously 0x0 → BYPASS = 1: rs1_data_o = 0x12345678; BYPASS = 0: rs1_data_o = 0x0, and a next-cycle read gives 0x12345678.
- Write x3 = 0xA5A5A5A5. Assert rstn_i low mid-operation for 2 cycles during a CLEAR restart, raising it at clr_cnt ≈ 10 → sequence restarts, ready_o rises 31 edges after release, x3 reads 0.
- During CLEAR, drive rd_we_i = 1 to x9 = 0x55 → ignored: after ready_o rises, x9 reads 0. Toggle re low for several cycles → data_o holds its last value.
